// File: rtl/pll_reconfig_pkg.sv
// Shared constants for the PLL reconfiguration controller: register map, PLL bus
// field offsets, STATUS bit positions and the sequencer state type.
package pll_reconfig_pkg;

  localparam logic [2:0] RegStatus  = 3'd0;
  localparam logic [2:0] RegCtrl    = 3'd1;
  localparam logic [2:0] RegCmdAddr = 3'd2;
  localparam logic [2:0] RegCmdData = 3'd3;
  localparam logic [2:0] RegLastRd  = 3'd4;

  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlFlushBit = 1;

  localparam int unsigned ToPllDataLsb  = 0;
  localparam int unsigned ToPllAddrLsb  = 32;
  localparam int unsigned ToPllWriteBit = 38;
  localparam int unsigned ToPllStartBit = 39;

  localparam int unsigned FromPllDataLsb = 0;
  localparam int unsigned FromPllBusyBit = 32;

  localparam int unsigned StatusBusyBit   = 0;
  localparam int unsigned StatusLockedBit = 1;
  localparam int unsigned StatusErrorBit  = 2;
  localparam int unsigned StatusDoneBit   = 3;
  localparam int unsigned StatusFullBit   = 4;
  localparam int unsigned StatusCountLsb  = 5;

  // FIFO entry layout: {pll_addr[5:0], data[31:0]}
  localparam int unsigned CmdWidth = 38;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StApply,
    StWaitBusy,
    StWaitIdle,
    StWaitLock,
    StDone
  } pll_state_e;

  function automatic logic [63:0] pack_write(input logic [CmdWidth-1:0] cmd);
    logic [63:0] v;
    v = '0;
    v[ToPllDataLsb +: 32] = cmd[31:0];
    v[ToPllAddrLsb +: 6]  = cmd[37:32];
    v[ToPllWriteBit]      = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pll_reconfig_cmd_fifo.sv
// Command buffer for the PLL reconfiguration controller: synchronous push/pop with
// flush, full/empty flags and an occupancy count. Depth must be a power of two.
module pll_reconfig_cmd_fifo
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = CmdWidth,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pushes into a full buffer are dropped; the owner flags the error.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Avalon-MM controlled PLL reconfiguration sequencer: buffers address/data commands,
// streams them to the PLL, then starts and waits for busy/idle/lock.
// Optional wait-state timeout is enabled by defining PLL_RECONFIG_TIMEOUT_EN.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        pll_locked,
  output logic [63:0] reconfig_to_pll,
  input  logic [63:0] reconfig_from_pll,
  output logic        irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  pll_state_e          state_q, state_d;
  logic [5:0]          cmd_addr_q;
  logic [31:0]         last_rd_q, last_rd_d;
  logic [31:0]         readdata_q, readdata_d;
  logic [31:0]         status;
  logic [63:0]         to_pll_q, to_pll_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                locked_meta_q, locked_sync_q;
  logic                wr_ctrl, flush, start_req, cmd_push, pll_busy;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [CmdWidth-1:0] fifo_rdata;
  logic [CntW-1:0]     fifo_count;
  logic                timeout_hit;
  logic                unused_from_pll;

  assign wr_ctrl   = avs_write && (avs_address == RegCtrl);
  assign flush     = wr_ctrl && avs_writedata[CtrlFlushBit];
  assign start_req = wr_ctrl && avs_writedata[CtrlStartBit] && !flush;
  assign cmd_push  = avs_write && (avs_address == RegCmdData);
  assign pll_busy  = reconfig_from_pll[FromPllBusyBit];

  assign unused_from_pll = ^reconfig_from_pll[63:33];

  pll_reconfig_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CmdWidth)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (cmd_push),
    .wdata_i ({cmd_addr_q, avs_writedata}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef PLL_RECONFIG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            in_wait;

  assign in_wait     = (state_q == StWaitBusy) || (state_q == StWaitIdle) ||
                       (state_q == StWaitLock);
  assign timeout_hit = in_wait && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

  // Restarts on every state change so each wait state gets its own budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (!in_wait || (state_d != state_q)) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
    end
  end
`else
  localparam int unsigned UnusedTimeoutCyc = TIMEOUT_CYC;

  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    to_pll_d  = '0;
    fifo_pop  = 1'b0;
    done_d    = done_q;
    error_d   = error_q;
    last_rd_d = last_rd_q;

    if (cmd_push && fifo_full) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_req && !fifo_empty && !error_q) begin
          state_d = StLoad;
          done_d  = 1'b0;
        end
      end
      StLoad: begin
        if (fifo_empty) begin
          state_d = StApply;
        end else begin
          fifo_pop = 1'b1;
          to_pll_d = pack_write(fifo_rdata);
        end
      end
      StApply: begin
        to_pll_d[ToPllStartBit] = 1'b1;
        state_d                 = StWaitBusy;
      end
      StWaitBusy: begin
        if (pll_busy) begin
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (!pll_busy) begin
          state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        if (locked_sync_q) begin
          state_d   = StDone;
          last_rd_d = reconfig_from_pll[FromPllDataLsb +: 32];
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (timeout_hit) begin
      state_d = StIdle;
      error_d = 1'b1;
    end

    // Flush overrides everything, including a start written in the same word.
    if (flush) begin
      state_d  = StIdle;
      to_pll_d = '0;
      fifo_pop = 1'b0;
      error_d  = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_comb begin
    status                             = '0;
    status[StatusBusyBit]              = (state_q != StIdle);
    status[StatusLockedBit]            = locked_sync_q;
    status[StatusErrorBit]             = error_q;
    status[StatusDoneBit]              = done_q;
    status[StatusFullBit]              = fifo_full;
    status[StatusCountLsb +: 5]        = 5'(fifo_count);

    readdata_d = readdata_q;
    if (avs_read) begin
      case (avs_address)
        RegStatus: readdata_d = status;
        RegLastRd: readdata_d = last_rd_q;
        default:   readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cmd_addr_q    <= '0;
      last_rd_q     <= '0;
      readdata_q    <= '0;
      to_pll_q      <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      locked_meta_q <= 1'b0;
      locked_sync_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_rd_q     <= last_rd_d;
      readdata_q    <= readdata_d;
      to_pll_q      <= to_pll_d;
      done_q        <= done_d;
      error_q       <= error_d;
      locked_meta_q <= pll_locked;
      locked_sync_q <= locked_meta_q;
      if (avs_write && (avs_address == RegCmdAddr)) begin
        cmd_addr_q <= avs_writedata[5:0];
      end
    end
  end

  assign avs_readdata    = readdata_q;
  assign reconfig_to_pll = to_pll_q;
  assign irq             = done_q | error_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: register table, directed sequences, and
// randomized command batches checked against a queue-based model of the sequencer.
module tb_pll_reconfig_ctrl;
  import pll_reconfig_pkg::*;

  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        pll_locked = 1'b1;
  logic        pll_busy = 1'b0;
  logic [31:0] pll_rd = '0;
  logic [63:0] reconfig_to_pll;
  logic [63:0] reconfig_from_pll;
  logic        irq;

  assign reconfig_from_pll = {31'h2AAA_AAAA, pll_busy, pll_rd};

  pll_reconfig_ctrl #(
    .FIFO_DEPTH  (Depth),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .pll_locked        (pll_locked),
    .reconfig_to_pll   (reconfig_to_pll),
    .reconfig_from_pll (reconfig_from_pll),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, exp);
    end
  endtask

  // PLL model: on a start pulse, busy for 10 cycles, then lock after lock_delay cycles.
  bit react = 1'b1;
  int lock_delay = 0;
  int busy_left = 0;
  int lock_left = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (react && reconfig_to_pll[ToPllStartBit]) begin
      busy_left  = 10;
      lock_left  = lock_delay;
      pll_locked = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (lock_left > 0) begin
      lock_left--;
    end else begin
      pll_locked = 1'b1;
    end
    pll_busy = (busy_left > 0);
  end

  // Monitor of the command bus.
  typedef struct {
    logic [37:0] cmd;
    int          cyc;
  } wr_rec_t;
  wr_rec_t wr_log[$];
  int      start_log[$];
  initial forever begin
    @(negedge clk);
    if (reconfig_to_pll != 64'h0) begin
      check("to_pll_shape",
            {63'h0, (reconfig_to_pll[63:40] == 24'h0) &&
                    (reconfig_to_pll[38] ^ reconfig_to_pll[39])}, 64'h1);
      if (reconfig_to_pll[38]) wr_log.push_back('{reconfig_to_pll[37:0], cyc});
      if (reconfig_to_pll[39]) start_log.push_back(cyc);
    end
  end

  // Behavioural model of the controller's visible state.
  logic [37:0] m_q[$];
  logic [37:0] m_exp[$];
  bit          m_err = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_last = '0;

  function automatic logic [31:0] exp_status(input bit busy, input bit locked);
    return {22'h0, 5'(m_q.size()), m_q.size() == Depth, m_done, m_err, locked, busy};
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d        = avs_readdata;
  endtask

  task automatic push(input logic [5:0] a, input logic [31:0] d);
    bus_write(RegCmdAddr, {26'h0, a});
    bus_write(RegCmdData, d);
    if (m_q.size() == Depth) m_err = 1'b1;
    else m_q.push_back({a, d});
  endtask

  task automatic do_flush();
    bus_write(RegCtrl, 32'h2);
    m_q.delete();
    m_err  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic do_start(output bit accepted);
    bus_write(RegCtrl, 32'h1);
    accepted = (m_q.size() > 0) && !m_err;
    if (accepted) begin
      m_exp  = m_q;
      m_q.delete();
      m_done = 1'b0;
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    start_log.delete();
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] r;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      bus_read(RegStatus, r);
      if (!r[StatusBusyBit]) ok = 1'b1;
    end
    check({nm, "_idle_bound"}, {63'h0, ok}, 64'h1);
  endtask

  task automatic wait_start(input string nm, output int c0);
    bit found;
    found = 1'b0;
    c0    = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (start_log.size() > 0) begin
        found = 1'b1;
        c0    = start_log[0];
      end
    end
    check({nm, "_start_seen"}, {63'h0, found}, 64'h1);
  endtask

  task automatic run_check(input string nm);
    wait_idle(nm);
    m_done = 1'b1;
    m_last = pll_rd;
    check({nm, "_nwr"}, 64'(wr_log.size()), 64'(m_exp.size()));
    foreach (m_exp[i]) begin
      if (i < wr_log.size()) begin
        check($sformatf("%s_wr%0d", nm, i), 64'(wr_log[i].cmd), 64'(m_exp[i]));
        check($sformatf("%s_wrcyc%0d", nm, i), 64'(wr_log[i].cyc), 64'(wr_log[0].cyc + i));
      end
    end
    check({nm, "_nstart"}, 64'(start_log.size()), 64'd1);
    if (start_log.size() > 0 && wr_log.size() > 0) begin
      check({nm, "_start_after"}, {63'h0, start_log[0] > wr_log[wr_log.size()-1].cyc}, 64'h1);
    end
  endtask

  task automatic check_regs(input string nm, input bit locked);
    logic [31:0] r;
    bus_read(RegStatus, r);
    check({nm, "_status"}, 64'(r), 64'(exp_status(1'b0, locked)));
    bus_read(RegLastRd, r);
    check({nm, "_last_rd"}, 64'(r), 64'(m_last));
    check({nm, "_irq"}, {63'h0, irq}, {63'h0, m_done | m_err});
  endtask

  typedef struct {
    bit          is_rd;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  initial begin
    logic [31:0] r;
    bit          acc;
    bit          found;
    int          c0;
    int          n;

    vecs[0]  = '{1'b1, 3'd1, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 3'd2, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 3'd3, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 3'd4, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 3'd7, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 3'd0, 32'h0, 32'h2};
    vecs[6]  = '{1'b0, 3'd5, 32'hFFFF_FFFF, 32'h2};
    vecs[7]  = '{1'b0, 3'd2, 32'h4, 32'h2};
    vecs[8]  = '{1'b0, 3'd3, 32'h808, 32'h22};
    vecs[9]  = '{1'b0, 3'd1, 32'h3, 32'h2};
    vecs[10] = '{1'b0, 3'd3, 32'h1, 32'h22};
    vecs[11] = '{1'b0, 3'd3, 32'h2, 32'h42};
    vecs[12] = '{1'b0, 3'd1, 32'h2, 32'h2};
    vecs[13] = '{1'b0, 3'd1, 32'h1, 32'h2};
    vecs[14] = '{1'b1, 3'd2, 32'h0, 32'h0};

    repeat (3) @(negedge clk);
    check("rst_to_pll", reconfig_to_pll, 64'h0);
    check("rst_irq", {63'h0, irq}, 64'h0);
    check("rst_rdata", 64'(avs_readdata), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Register map table
    clear_logs();
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_rd) begin
        bus_read(vecs[i].addr, r);
      end else begin
        bus_write(vecs[i].addr, vecs[i].data);
        bus_read(RegStatus, r);
      end
      check($sformatf("table%0d", i), 64'(r), 64'(vecs[i].exp));
    end
    repeat (10) @(negedge clk);
    check("table_no_wr", 64'(wr_log.size()), 64'd0);
    check("table_no_start", 64'(start_log.size()), 64'd0);

    // Single command
    do_flush();
    clear_logs();
    pll_rd = 32'h1234_0808;
    push(6'h04, 32'h0000_0808);
    do_start(acc);
    run_check("single");
    if (wr_log.size() > 0) check("single_cmd", 64'(wr_log[0].cmd), {26'h0, 6'h04, 32'h808});
    bus_read(RegStatus, r);
    check("single_status", 64'(r), 64'h0A);
    check("single_irq", {63'h0, irq}, 64'h1);
    bus_read(RegLastRd, r);
    check("single_last_rd", 64'(r), 64'h1234_0808);

    // Start with empty FIFO leaves STATUS alone
    clear_logs();
    do_start(acc);
    repeat (20) @(negedge clk);
    check("empty_no_wr", 64'(wr_log.size()), 64'd0);
    check("empty_no_start", 64'(start_log.size()), 64'd0);
    bus_read(RegStatus, r);
    check("empty_status", 64'(r), 64'h0A);

    // Burst with overflow
    do_flush();
    clear_logs();
    for (int i = 0; i < 8; i++) push(6'(i + 8), 32'h100 + 32'(i));
    push(6'h3F, 32'hDEAD_BEEF);
    bus_read(RegStatus, r);
    check("burst_ovf_status", 64'(r), 64'h116);
    check("burst_ovf_irq", {63'h0, irq}, 64'h1);
    do_start(acc);
    repeat (20) @(negedge clk);
    check("burst_ign_wr", 64'(wr_log.size()), 64'd0);
    check("burst_ign_start", 64'(start_log.size()), 64'd0);
    bus_read(RegStatus, r);
    check("burst_ign_status", 64'(r), 64'h116);
    do_flush();
    bus_read(RegStatus, r);
    check("burst_flush_status", 64'(r), 64'h2);
    check("burst_flush_irq", {63'h0, irq}, 64'h0);
    pll_rd = 32'h0BAD_F00D;
    for (int i = 0; i < 8; i++) push(6'(i * 5), $urandom);
    do_start(acc);
    run_check("burst");
    check_regs("burst", 1'b1);

`ifdef PLL_RECONFIG_TIMEOUT_EN
    // Timeout in WAIT_BUSY
    react = 1'b0;
    do_flush();
    clear_logs();
    push(6'h01, 32'h1);
    do_start(acc);
    wait_start("tmo", c0);
    while (cyc < c0 + 99) @(negedge clk);
    check("tmo_before", {63'h0, irq}, 64'h0);
    @(negedge clk);
    check("tmo_irq", {63'h0, irq}, 64'h1);
    check("tmo_to_pll", reconfig_to_pll, 64'h0);
    m_err = 1'b1;
    bus_read(RegStatus, r);
    check("tmo_status", 64'(r), 64'h6);
    react = 1'b1;
    do_flush();
`else
    // Without the timeout a silent PLL leaves the sequencer waiting
    react = 1'b0;
    do_flush();
    clear_logs();
    push(6'h01, 32'h1);
    do_start(acc);
    repeat (150) @(negedge clk);
    bus_read(RegStatus, r);
    check("notmo_status", 64'(r), 64'h3);
    react = 1'b1;
    do_flush();
    bus_read(RegStatus, r);
    check("notmo_flush_status", 64'(r), 64'h2);
`endif

    // Flush during WAIT_LOCK, with one command queued while busy
    lock_delay = 30;
    do_flush();
    clear_logs();
    push(6'h02, 32'h22);
    do_start(acc);
    wait_start("fwl", c0);
    while (cyc < c0 + 12) @(negedge clk);
    push(6'h03, 32'h33);
    bus_read(RegStatus, r);
    check("fwl_busy_push", 64'(r), 64'h21);
    @(negedge clk);
    avs_address   = RegCtrl;
    avs_writedata = 32'h2;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write   = 1'b0;
    avs_address = RegStatus;
    avs_read    = 1'b1;
    m_q.delete();
    m_err  = 1'b0;
    m_done = 1'b0;
    check("fwl_to_pll", reconfig_to_pll, 64'h0);
    check("fwl_irq", {63'h0, irq}, 64'h0);
    @(negedge clk);
    avs_read = 1'b0;
    check("fwl_status", 64'(avs_readdata), 64'h0);
    repeat (60) @(negedge clk);
    check("fwl_no_more_start", 64'(start_log.size()), 64'd1);
    check("fwl_no_more_wr", 64'(wr_log.size()), 64'd1);
    lock_delay = 0;

    // Reset asserted during LOAD
    do_flush();
    for (int i = 0; i < 4; i++) push(6'(i), 32'hA0 + 32'(i));
    do_start(acc);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (reconfig_to_pll[ToPllWriteBit]) found = 1'b1;
    end
    check("rstld_in_load", {63'h0, found}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("rstld_to_pll", reconfig_to_pll, 64'h0);
    check("rstld_irq", {63'h0, irq}, 64'h0);
    m_q.delete();
    m_err  = 1'b0;
    m_done = 1'b0;
    m_last = '0;
    clear_logs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rstld_no_wr", 64'(wr_log.size()), 64'd0);
    check("rstld_no_start", 64'(start_log.size()), 64'd0);
    check_regs("rstld", 1'b1);

    // Randomized batches against the model
    for (int rnd = 0; rnd < 8; rnd++) begin
      if ($urandom_range(0, 1) == 1) do_flush();
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) push(6'($urandom_range(0, 63)), $urandom);
      pll_rd = $urandom;
      clear_logs();
      do_start(acc);
      if (acc) begin
        run_check($sformatf("rnd%0d", rnd));
      end else begin
        repeat (20) @(negedge clk);
        check($sformatf("rnd%0d_ign_wr", rnd), 64'(wr_log.size()), 64'd0);
        check($sformatf("rnd%0d_ign_start", rnd), 64'(start_log.size()), 64'd0);
      end
      check_regs($sformatf("rnd%0d", rnd), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
